ram_stream_buffer: RTL and testbench

Stream-to-RAM frame buffer controller that sits directly upstream of `single_port_ram` and drives its `data`/`addr`/`we` port, consuming its `q`. It accepts a frame of words on a valid/ready input stream and writes them to consecutive RAM addresses starting at 0. It then reads the frame back in the same order and presents it on a valid/ready output stream. One frame is resident at a time: fill, then drain, then fill again.

---
 rtl/ram_stream_buffer_if.sv | 53 +++++
 rtl/ram_stream_buffer.sv | 159 +++++++++++++++
 tb/tb_ram_stream_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_buffer_if.sv
// ---------------------------------------------------------------------------
// ram_stream_buffer_if
//
// Purpose: bundles every non-clock signal of ram_stream_buffer: the input
// stream, the output stream, the single-port RAM port and the frame status.
//
// Signals:
//   s_data/s_valid/s_last/s_ready  input stream (s_ready driven by controller)
//   m_data/m_valid/m_last/m_ready  output stream (m_ready driven by consumer)
//   ram_data/ram_addr/ram_we       controller -> RAM
//   ram_q                          RAM -> controller (registered-address read)
//   frame_len/trunc                status of the resident frame
//
// Modports:
//   master  the controller (ram_stream_buffer)
//   slave   its surroundings: upstream source, downstream sink and the RAM
// ---------------------------------------------------------------------------
interface ram_stream_buffer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  logic [ADDR_W:0]   frame_len;
  logic              trunc;

  modport master (
    input  s_data, s_valid, s_last, m_ready, ram_q,
    output s_ready, m_data, m_valid, m_last,
           ram_data, ram_addr, ram_we, frame_len, trunc
  );

  modport slave (
    output s_data, s_valid, s_last, m_ready, ram_q,
    input  s_ready, m_data, m_valid, m_last,
           ram_data, ram_addr, ram_we, frame_len, trunc
  );

endinterface

// File: rtl/ram_stream_buffer.sv
// ---------------------------------------------------------------------------
// ram_stream_buffer
//
// Purpose: single-frame stream buffer in front of a single-port RAM whose
// read data appears one cycle after the address is registered. A frame is
// written to addresses 0.. on the input stream, then read back in order on
// the output stream; only one frame is resident at a time.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ram_stream_buffer_if.master: s_* input stream, m_* output stream,
//          ram_* RAM port, frame_len / trunc status of the resident frame
//
// Parameters: ADDR_W (RAM address width), DATA_W (word width),
//             DEPTH (RAM words, must be 2**ADDR_W).
// ---------------------------------------------------------------------------
module ram_stream_buffer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_stream_buffer_if.master bus
);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAPT  = 2'd2,
    RD_HOLD  = 2'd3
  } state_e;

  // Pointer value of the last RAM slot; accepting a word here fills the RAM.
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic              trunc_q, trunc_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;

  logic              s_ready;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      trunc_q     <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      trunc_q     <= trunc_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    trunc_d     = trunc_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    s_ready     = 1'b0;
    accept      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = rd_ptr_q[ADDR_W-1:0];

    unique case (state_q)
      FILL: begin
        // rst_n gating keeps the stream closed and the RAM write-protected
        // while reset is held, even though the state already reads FILL.
        s_ready  = rst_n;
        ram_we   = bus.s_valid & rst_n;
        ram_addr = wr_ptr_q[ADDR_W-1:0];
        accept   = bus.s_valid & s_ready;
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus.s_last || (wr_ptr_q == LAST_SLOT)) begin
            frame_len_d = wr_ptr_q + 1'b1;
            trunc_d     = ~bus.s_last;
            rd_ptr_d    = '0;
            state_d     = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        // Address is registered by the RAM at the end of this cycle.
        state_d = RD_CAPT;
      end

      RD_CAPT: begin
        // ram_q now reflects rd_ptr; capture it into the output register.
        m_data_d  = bus.ram_q;
        m_valid_d = 1'b1;
        m_last_d  = (rd_ptr_q == (frame_len_q - 1'b1));
        state_d   = RD_HOLD;
      end

      RD_HOLD: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            wr_ptr_d = '0;
            state_d  = FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = RD_ISSUE;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign bus.s_ready   = s_ready;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_data  = bus.s_data;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;
  assign bus.frame_len = frame_len_q;
  assign bus.trunc     = trunc_q;

endmodule

// File: tb/tb_ram_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_buffer
//
// Purpose: self-checking bench for ram_stream_buffer. Includes a behavioural
// single-port RAM (registered address, one-cycle read) and a frame-level
// reference: the words accepted on the input stream form the expected output
// frame, closed by s_last or by the 64th word.
// ---------------------------------------------------------------------------
module tb_ram_stream_buffer;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_stream_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_stream_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural RAM: write on we, address registered every edge.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] addr_r;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    addr_r <= bus.ram_addr;
  end
  assign bus.ram_q = mem[addr_r];

  // Reference model state and counters
  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  stim_d [0:DEPTH-1];
  logic [7:0]  exp_q [$];
  int          exp_len;
  bit          exp_trunc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n words from stim_d; s_last on the final one when use_last.
  // Called at a negedge. Returns at the negedge after the closing accept.
  task automatic fill(input int n, input bit use_last, input bit gaps);
    int k = 0;
    int guard = 0;
    exp_q.delete();
    while (k < n) begin
      if (guard > 1000) begin
        chk("fill_timeout", k, n);
        break;
      end
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        #1;
        chk("fill_idle_ready", bus.s_ready, 1);
        chk("fill_idle_we", bus.ram_we, 0);
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = stim_d[k];
        bus.s_last  = use_last && (k == n - 1);
        #1;
        chk("fill_ready", bus.s_ready, 1);
        chk("fill_we", bus.ram_we, 1);
        chk("fill_addr", bus.ram_addr, k % DEPTH);
        chk("fill_data", bus.ram_data, stim_d[k]);
        exp_q.push_back(stim_d[k]);
        k++;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'($urandom);
    exp_len   = k;
    exp_trunc = !(use_last && k == n);
    for (int j = 0; j < k; j++) chk("ram_content", mem[j], exp_q[j]);
  endtask

  // Consume the frame. stall_idx/stall_cyc: hold m_ready low on that word.
  // rnd: random m_ready. abort_idx: pulse reset while that word is held.
  task automatic drain(input int stall_idx, input int stall_cyc, input bit rnd,
                       input int abort_idx);
    int i = 0;
    int cyc = 0;
    int held = 0;
    int last_hs = -1;
    bit prev_v = 1'b0;
    chk("frame_len", bus.frame_len, exp_len);
    chk("trunc", bus.trunc, exp_trunc);
    while (i < exp_q.size()) begin
      if (cyc > 1000) begin
        chk("drain_timeout", i, exp_q.size());
        bus.m_ready = 1'b0;
        return;
      end
      chk("drain_s_ready", bus.s_ready, 0);
      chk("drain_we", bus.ram_we, 0);
      if (bus.m_valid && !prev_v) begin
        if (last_hs < 0) chk("first_latency", cyc, 2);
        else             chk("reissue_gap", cyc - last_hs, 3);
      end
      prev_v = bus.m_valid;
      if (bus.m_valid) begin
        chk("m_data", bus.m_data, exp_q[i]);
        chk("m_last", bus.m_last, (i == exp_q.size() - 1) ? 1 : 0);
        if (i == abort_idx) begin
          bus.m_ready = 1'b0;
          bus.s_valid = 1'b1;
          bus.s_data  = 8'hEE;
          #2 rst_n = 1'b0;
          #1;
          chk("rst_m_valid", bus.m_valid, 0);
          chk("rst_s_ready", bus.s_ready, 0);
          chk("rst_we", bus.ram_we, 0);
          chk("rst_m_data", bus.m_data, 0);
          chk("rst_frame_len", bus.frame_len, 0);
          @(negedge clk);
          rst_n       = 1'b1;
          bus.s_valid = 1'b0;
          #1;
          chk("post_rst_s_ready", bus.s_ready, 1);
          chk("post_rst_trunc", bus.trunc, 0);
          @(negedge clk);
          return;
        end
        if (i == stall_idx && held < stall_cyc) begin
          bus.m_ready = 1'b0;
          held++;
        end else begin
          bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.m_ready) begin
          i++;
          last_hs = cyc;
        end
      end else begin
        chk("idle_m_last", bus.m_last, 0);
        bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.m_ready = 1'b0;
    chk("refill_s_ready", bus.s_ready, 1);
    chk("post_m_valid", bus.m_valid, 0);
    chk("kept_frame_len", bus.frame_len, exp_len);
    chk("kept_trunc", bus.trunc, exp_trunc);
  endtask

  initial begin
    int n;
    bit use_last;
    rst_n       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h77;
    bus.m_ready = 1'b0;
    #1;
    chk("reset_s_ready", bus.s_ready, 0);
    chk("reset_we", bus.ram_we, 0);
    chk("reset_addr", bus.ram_addr, 0);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_last", bus.m_last, 0);
    chk("reset_m_data", bus.m_data, 0);
    chk("reset_frame_len", bus.frame_len, 0);
    chk("reset_trunc", bus.trunc, 0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word frame closed by s_last
    stim_d[0] = 8'h01; stim_d[1] = 8'h02; stim_d[2] = 8'h03;
    fill(3, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: 3-word frame done");

    // Full RAM without s_last -> truncated frame
    for (int j = 0; j < DEPTH; j++) stim_d[j] = 8'(j);
    fill(DEPTH, 1'b0, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: 64-word truncated frame done");

    // Consumer stall on the second word
    stim_d[0] = 8'hA0; stim_d[1] = 8'hA1; stim_d[2] = 8'hA2;
    fill(3, 1'b1, 1'b0);
    drain(1, 5, 1'b0, -1);
    $display("step: stalled drain done");

    // Single-word frame
    stim_d[0] = 8'h5A;
    fill(1, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: single-word frame done");

    // Reset while word 2 is held, then a fresh frame
    for (int j = 0; j < 4; j++) stim_d[j] = 8'($urandom);
    fill(4, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, 2);
    stim_d[0] = 8'h11; stim_d[1] = 8'h22;
    fill(2, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: mid-drain reset done");

    // Back-to-back frames, the second shorter than the first
    stim_d[0] = 8'h01; stim_d[1] = 8'h02;
    fill(2, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    stim_d[0] = 8'h03;
    fill(1, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: back-to-back frames done");

    // Full RAM closed by s_last on the 64th word -> not truncated
    for (int j = 0; j < DEPTH; j++) stim_d[j] = 8'($urandom);
    fill(DEPTH, 1'b1, 1'b0);
    drain(-1, 0, 1'b0, -1);
    $display("step: 64-word frame with s_last done");

    // Randomised frames with input gaps and random back-pressure
    for (int f = 0; f < 12; f++) begin
      if (f % 4 == 3) begin
        n = DEPTH;
        use_last = 1'b0;
      end else begin
        n = $urandom_range(1, DEPTH);
        use_last = 1'b1;
      end
      for (int j = 0; j < n; j++) stim_d[j] = 8'($urandom);
      fill(n, use_last, 1'b1);
      drain(-1, 0, 1'b1, -1);
      $display("step: random frame %0d len %0d done", f, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
